// File: rtl/wb_master_arb.sv
// Two-requester Wishbone arbiter in front of a single shared master port.
// Round-robin on ties, one idle bus cycle between owners, and a watchdog
// that terminates stalled transfers with an error to the owner.
module wb_master_arb #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic        m0_cab_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_rty_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic        m1_cab_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_rty_o,
    output logic        m1_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic        wbm_cab_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_rty_i,
    input  logic        wbm_err_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;

    state_t      state;
    logic        owner;
    logic        last_owner;
    logic [7:0]  wdog;
    logic        err_pulse;

    logic        own_cyc;
    logic        own_stb;
    logic        term;

    assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner ? m1_stb_i : m0_stb_i;
    assign term    = wbm_ack_i | wbm_rty_i | wbm_err_i;

    // Arbitration state, owner tracking and stall watchdog
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wdog       <= '0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (m0_cyc_i && m1_cyc_i) begin
                        owner <= ~last_owner;
                        state <= BUSY;
                    end else if (m0_cyc_i) begin
                        owner <= 1'b0;
                        state <= BUSY;
                    end else if (m1_cyc_i) begin
                        owner <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        wdog       <= '0;
                    end else if (term) begin
                        // a bridge termination beats a watchdog expiry in the same cycle
                        wdog <= '0;
                    end else if ((TIMEOUT != 8'd0) && (wdog == TIMEOUT)) begin
                        state     <= TERM;
                        err_pulse <= 1'b1;
                    end else if (own_stb && (wdog != TIMEOUT)) begin
                        wdog <= wdog + 8'd1;
                    end
                end
                TERM: begin
                    if (!own_cyc) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        wdog       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared-port mirroring and termination routing to the current owner
    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_cab_o = 1'b0;
        wbm_sel_o = '0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        m0_ack_o  = 1'b0;
        m0_rty_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_rty_o  = 1'b0;
        m1_err_o  = 1'b0;
        gnt_o     = 2'b00;
        if (state == BUSY) begin
            gnt_o = owner ? 2'b10 : 2'b01;
            if (owner) begin
                wbm_cyc_o = m1_cyc_i;
                wbm_stb_o = m1_stb_i;
                wbm_we_o  = m1_we_i;
                wbm_cab_o = m1_cab_i;
                wbm_sel_o = m1_sel_i;
                wbm_adr_o = m1_adr_i;
                wbm_dat_o = m1_dat_i;
                m1_ack_o  = wbm_ack_i;
                m1_rty_o  = wbm_rty_i;
                m1_err_o  = wbm_err_i;
            end else begin
                wbm_cyc_o = m0_cyc_i;
                wbm_stb_o = m0_stb_i;
                wbm_we_o  = m0_we_i;
                wbm_cab_o = m0_cab_i;
                wbm_sel_o = m0_sel_i;
                wbm_adr_o = m0_adr_i;
                wbm_dat_o = m0_dat_i;
                m0_ack_o  = wbm_ack_i;
                m0_rty_o  = wbm_rty_i;
                m0_err_o  = wbm_err_i;
            end
        end else if (state == TERM) begin
            gnt_o = owner ? 2'b10 : 2'b01;
            if (owner) begin
                m1_err_o = err_pulse;
            end else begin
                m0_err_o = err_pulse;
            end
        end
    end

    assign m0_dat_o = wbm_dat_i;
    assign m1_dat_o = wbm_dat_i;

endmodule
